// File: rtl/sync_pkg.sv
// ---------------------------------------------------------------------------
// sync_pkg
// Shared definitions for the result buffer that sits behind the synchronous
// bitwise AND stage.
//   DATA_WIDTH   : default data width (matches the AND stage)
//   FIFO_DEPTH   : default number of buffer entries (power of 2, >= 2)
//   fifo_state_t : 3-state occupancy view (EMPTY / PARTIAL / FULL)
// ---------------------------------------------------------------------------
package sync_pkg;

  localparam int DATA_WIDTH = 4;
  localparam int FIFO_DEPTH = 8;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } fifo_state_t;

endpackage : sync_pkg

// File: rtl/sync_fifo_mem.sv
// ---------------------------------------------------------------------------
// sync_fifo_mem
// DEPTH x WIDTH register array used as the storage of sync_result_fifo.
//   clk   : rising-edge clock
//   rst   : asynchronous active-high clear of every entry
//   we    : write enable, stores wdata at waddr on the clock edge
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : combinational read data (mem[raddr])
// The read port is combinational so the FIFO head can fall through to the
// output in the cycle after it is written.
// ---------------------------------------------------------------------------
module sync_fifo_mem #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Entries are cleared on reset so the head word reads as zero afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule : sync_fifo_mem

// File: rtl/sync_result_fifo.sv
// ---------------------------------------------------------------------------
// sync_result_fifo
// Buffers the registered AND result for a downstream consumer.
//   clk       : rising-edge clock shared with the AND stage
//   rst       : asynchronous active-high reset
//   in_data   : word from the AND stage output c
//   in_valid  : in_data carries a word this cycle
//   in_ready  : not full, a word can be accepted
//   out_data  : head-of-FIFO word (first-word-fall-through)
//   out_valid : not empty, out_data is valid
//   out_ready : consumer takes the head word this cycle
//   count     : stored words, 0..DEPTH
//   overflow  : sticky, a word was offered while full (cleared by rst only)
// The producer cannot be stalled, so a word offered while full is dropped
// and only recorded through overflow.
// ---------------------------------------------------------------------------
module sync_result_fifo
  import sync_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH,
  parameter int DEPTH = FIFO_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [AW:0]      count,
  output logic             overflow
);

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // without a separate state register.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             overflow_q, overflow_d;
  fifo_state_t      state;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] rdata;

  // Occupancy view decoded from the registered pointers.
  always_comb begin
    state = PARTIAL;
    if (wr_ptr_q == rd_ptr_q) begin
      state = EMPTY;
    end else if (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) begin
      // Low bits equal but pointers differ, so only the wrap bit differs.
      state = FULL;
    end
  end

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (in_valid && !in_ready) begin
      overflow_d = 1'b1;
    end
    // Modular difference of the wrap-bit pointers is the occupancy.
    count_d = wr_ptr_d - rd_ptr_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  sync_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (push),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (in_data),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (rdata)
  );

  assign out_data = rdata;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule : sync_result_fifo

// File: tb/tb_sync_result_fifo.sv
// ---------------------------------------------------------------------------
// tb_sync_result_fifo
// Self-checking bench: a queue-based reference model of the buffer is
// compared against the DUT on every falling edge, and directed sequences add
// literal expectations for reset, single word, fill/drain, overflow,
// concurrent traffic with pointer wrap, and asynchronous reset mid-stream.
// ---------------------------------------------------------------------------
module tb_sync_result_fifo;
  import sync_pkg::*;

  localparam int WIDTH = DATA_WIDTH;
  localparam int DEPTH = FIFO_DEPTH;
  localparam int AW    = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [AW:0]      count;
  logic             overflow;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [WIDTH-1:0] m_q[$];
  bit               m_ovf;

  always #5 clk = ~clk;

  sync_result_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .overflow  (overflow)
  );

  function automatic fifo_state_t state_of(int n);
    if (n == 0) return EMPTY;
    if (n == DEPTH) return FULL;
    return PARTIAL;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO of capacity DEPTH, word dropped when full.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_ovf = 1'b0;
    end else begin
      int  sz;
      bit  do_pop;
      bit  do_push;
      sz      = m_q.size();
      do_pop  = out_ready && (sz > 0);
      do_push = in_valid && (sz < DEPTH);
      if (in_valid && sz == DEPTH) m_ovf = 1'b1;
      if (do_pop) void'(m_q.pop_front());
      if (do_push) m_q.push_back(in_data);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      fifo_state_t st;
      st = state_of(m_q.size());
      chk("count", int'(count), m_q.size());
      chk("in_ready", int'(in_ready), int'(st != FULL));
      chk("out_valid", int'(out_valid), int'(st != EMPTY));
      chk("overflow", int'(overflow), int'(m_ovf));
      if (st != EMPTY) chk("out_data", int'(out_data), int'(m_q[0]));
    end
  end

  // Drive inputs for one cycle; returns just after the following falling edge.
  task automatic tick(input bit iv, input logic [WIDTH-1:0] d, input bit ordy);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    @(negedge clk);
    #1;
    $display("txn t=%0t iv=%0d d=%0h ordy=%0d -> cnt=%0d ov=%0d od=%0h ir=%0d of=%0d",
             $time, iv, d, ordy, count, out_valid, out_data, in_ready, overflow);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset then idle.
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_out_data", int'(out_data), 0);

    // Single word.
    tick(1'b1, 4'hA, 1'b0);
    chk("single_valid", int'(out_valid), 1);
    chk("single_data", int'(out_data), 'hA);
    chk("single_count", int'(count), 1);
    tick(1'b0, 4'h0, 1'b1);
    chk("single_pop_valid", int'(out_valid), 0);
    chk("single_pop_count", int'(count), 0);

    // Fill with 1..8 and no pops.
    for (int i = 1; i <= DEPTH; i++) tick(1'b1, WIDTH'(i), 1'b0);
    chk("fill_count", int'(count), DEPTH);
    chk("fill_in_ready", int'(in_ready), 0);

    // Offer a word while full: dropped, overflow set.
    tick(1'b1, 4'hF, 1'b0);
    chk("ovf_flag", int'(overflow), 1);
    chk("ovf_count", int'(count), DEPTH);

    // Drain: 1..8 in order, 4'hF absent.
    for (int i = 1; i <= DEPTH; i++) begin
      chk("drain_data", int'(out_data), i);
      tick(1'b0, 4'h0, 1'b1);
    end
    chk("drain_empty", int'(out_valid), 0);
    chk("ovf_sticky", int'(overflow), 1);

    // Concurrent push/pop at count 3 for 20 cycles (pointers wrap past 2*DEPTH).
    for (int i = 0; i < 3; i++) tick(1'b1, WIDTH'($urandom), 1'b0);
    chk("conc_pre_count", int'(count), 3);
    for (int i = 0; i < 20; i++) tick(1'b1, WIDTH'($urandom), 1'b1);
    chk("conc_count", int'(count), 3);

    // Randomized traffic with varying push/pop bias.
    for (int i = 0; i < 400; i++) begin
      int pv;
      int pr;
      pv = (i < 200) ? 70 : 35;
      pr = (i < 200) ? 40 : 75;
      tick($urandom_range(99) < pv, WIDTH'($urandom), $urandom_range(99) < pr);
    end
    chk("rand_ovf_sticky", int'(overflow), 1);

    // Async reset mid-stream at count 5.
    repeat (DEPTH + 1) tick(1'b0, 4'h0, 1'b1);
    for (int i = 0; i < 5; i++) tick(1'b1, WIDTH'(i + 9), 1'b0);
    chk("pre_arst_count", int'(count), 5);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_count", int'(count), 0);
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_in_ready", int'(in_ready), 1);
    chk("arst_out_data", int'(out_data), 0);
    chk("arst_overflow", int'(overflow), 0);
    @(negedge clk);
    #1;
    rst = 1'b0;

    // Short random run after reset.
    for (int i = 0; i < 60; i++)
      tick($urandom_range(1) == 1, WIDTH'($urandom), $urandom_range(1) == 1);

    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule : tb_sync_result_fifo
